// File: rtl/rca_mp_sequencer.sv
// Multi-precision add sequencer around an external ripple-carry adder.
// Optional OUT_OVF port when RCA_OVF_EN is defined.
module rca_mp_sequencer #(
  parameter int N     = 19,
  parameter int WORDS = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] IN_A,
  input  logic [N-1:0] IN_B,
  input  logic         IN_CIN,
  output logic [N-1:0] ADD_A,
  output logic [N-1:0] ADD_B,
  output logic         ADD_CIN,
  input  logic [N-1:0] ADD_SUM,
  input  logic         ADD_COUT,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] OUT_SUM,
  output logic         OUT_LAST,
`ifdef RCA_OVF_EN
  output logic         OUT_OVF,
`endif
  output logic         OUT_COUT
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] WMAX = CW'(WORDS - 1);

  logic          s1_valid;
  logic          s1_first;
  logic          s1_last;
  logic          s1_cin;
  logic          carry_q;
  logic [CW-1:0] wcnt;
  logic          adv2;
  logic          acc;
  logic          w_first;
  logic          w_last;

  always_comb begin
    adv2     = s1_valid && (!OUT_VALID || OUT_READY);
    IN_READY = !s1_valid || adv2;
    acc      = IN_VALID && IN_READY;
    w_first  = (wcnt == '0);
    w_last   = (wcnt == WMAX);
    // first word of an op never sees the previous op's carry
    ADD_CIN  = s1_first ? s1_cin : carry_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      ADD_A    <= '0;
      ADD_B    <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_cin   <= 1'b0;
      wcnt     <= '0;
    end else if (acc) begin
      s1_valid <= 1'b1;
      ADD_A    <= IN_A;
      ADD_B    <= IN_B;
      s1_first <= w_first;
      s1_last  <= w_last;
      s1_cin   <= IN_CIN;
      wcnt     <= w_last ? '0 : wcnt + 1'b1;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_SUM   <= '0;
      OUT_LAST  <= 1'b0;
      OUT_COUT  <= 1'b0;
      carry_q   <= 1'b0;
    end else if (adv2) begin
      OUT_VALID <= 1'b1;
      OUT_SUM   <= ADD_SUM;
      OUT_LAST  <= s1_last;
      OUT_COUT  <= s1_last & ADD_COUT;
      carry_q   <= ADD_COUT;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

`ifdef RCA_OVF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_OVF <= 1'b0;
    end else if (adv2) begin
      OUT_OVF <= s1_last
               & (ADD_A[N-1] == ADD_B[N-1])
               & (ADD_SUM[N-1] != ADD_A[N-1]);
    end
  end
`endif

endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Randomized bench for rca_mp_sequencer against a whole-operand sum model.
// Define RCA_OVF_EN to also check OUT_OVF.
module tb_rca_mp_sequencer;

  localparam int N     = 19;
  localparam int WORDS = 4;
  localparam int TW    = N * WORDS;

  typedef struct {
    logic [N-1:0] sum;
    logic         last;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [N-1:0] IN_A;
  logic [N-1:0] IN_B;
  logic         IN_CIN;
  logic [N-1:0] ADD_A;
  logic [N-1:0] ADD_B;
  logic         ADD_CIN;
  logic [N-1:0] ADD_SUM;
  logic         ADD_COUT;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [N-1:0] OUT_SUM;
  logic         OUT_LAST;
  logic         OUT_COUT;
  logic         ovf_w;

  int   n_chk  = 0;
  int   n_err  = 0;
  int   acc_cnt = 0;
  bit   stall  = 0;
  bit   rnd    = 0;
  bit   thru   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B} + {{N{1'b0}}, ADD_CIN};

  rca_mp_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .CLK      (clk),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_A     (IN_A),
    .IN_B     (IN_B),
    .IN_CIN   (IN_CIN),
    .ADD_A    (ADD_A),
    .ADD_B    (ADD_B),
    .ADD_CIN  (ADD_CIN),
    .ADD_SUM  (ADD_SUM),
    .ADD_COUT (ADD_COUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_SUM  (OUT_SUM),
    .OUT_LAST (OUT_LAST),
`ifdef RCA_OVF_EN
    .OUT_OVF  (ovf_w),
`endif
    .OUT_COUT (OUT_COUT)
  );

`ifndef RCA_OVF_EN
  assign ovf_w = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // expected words of one whole operation, from plain wide arithmetic
  task automatic model_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic cin);
    logic [TW:0] full;
    exp_t e;
    full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
    for (int i = 0; i < WORDS; i++) begin
      e.sum  = full[i*N +: N];
      e.last = (i == WORDS - 1);
      e.cout = e.last ? full[TW] : 1'b0;
      e.ovf  = e.last ? ((a[TW-1] == b[TW-1]) && (full[TW-1] != a[TW-1])) : 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic c);
    int t = 0;
    IN_A = a; IN_B = b; IN_CIN = c; IN_VALID = 1'b1;
    @(negedge clk);
    if (thru) check("thru", IN_READY, 1);
    while (!IN_READY && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!IN_READY) check("in_timeout", 0, 1);
    else acc_cnt++;
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    IN_A = N'($urandom); IN_B = N'($urandom); IN_CIN = 1'($urandom);
  endtask

  task automatic send_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic cin, input bit gap);
    model_op(a, b, cin);
    for (int i = 0; i < WORDS; i++) begin
      send_word(a[i*N +: N], b[i*N +: N], (i == 0) ? cin : 1'($urandom));
      if (gap) repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
  endtask

  function automatic logic [TW-1:0] rnd_op();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    case ($urandom % 4)
      0: return {TW{1'b1}};
      1: return TW'(r) | {1'b0, {(TW-1){1'b1}}};
      default: return TW'(r);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      OUT_READY = stall ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
    end
  end

  // scoreboard and output-hold monitor
  bit           held = 0;
  logic [N-1:0] hsum;
  logic         hlast;
  exp_t         e;
  always @(negedge clk) begin
    if (RST) held = 0;
    else begin
      if (held) begin
        check("hold_valid", OUT_VALID, 1);
        check("hold_sum", OUT_SUM, hsum);
        check("hold_last", OUT_LAST, hlast);
      end
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("sum", OUT_SUM, e.sum);
          check("last", OUT_LAST, e.last);
          check("cout", OUT_COUT, e.cout);
`ifdef RCA_OVF_EN
          check("ovf", ovf_w, e.ovf);
`endif
        end
      end
      held  = OUT_VALID && !OUT_READY;
      hsum  = OUT_SUM;
      hlast = OUT_LAST;
    end
  end

  initial begin
    int t;
    RST = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_CIN = 1'b0;
    OUT_READY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_sum", OUT_SUM, 0);
    check("rst_out_last", OUT_LAST, 0);
    check("rst_out_cout", OUT_COUT, 0);
    check("rst_add_a", ADD_A, 0);
    check("rst_add_b", ADD_B, 0);
    check("rst_add_cin", ADD_CIN, 0);
`ifdef RCA_OVF_EN
    check("rst_ovf", ovf_w, 0);
`endif
    @(posedge clk); #1;
    RST = 1'b0;

    // carry from word 0 into word 1
    send_op({{(2*N){1'b0}}, N'(1), N'('h7FFFF)},
            {{(3*N){1'b0}}, N'(1)}, 1'b0, 0);
    // full carry chain, back to back
    thru = 1;
    send_op({TW{1'b1}} >> 0, '0, 1'b1, 0);
    thru = 0;
    // isolation: previous op ends with carry-out
    send_op({TW{1'b1}}, TW'(1), 1'b0, 0);
    send_op(TW'(1), TW'(1), 1'b0, 0);
`ifdef RCA_OVF_EN
    send_op({N'('h3FFFF), {(3*N){1'b0}}}, {N'(1), {(3*N){1'b0}}}, 1'b0, 0);
    send_op({N'('h7FFFF), {(3*N){1'b0}}}, {N'(1), {(3*N){1'b0}}}, 1'b0, 0);
`endif
    repeat (4) @(posedge clk);
    #1;

    // backpressure
    stall = 1;
    @(posedge clk); #1;
    acc_cnt = 0;
    fork
      send_op(rnd_op(), rnd_op(), 1'($urandom), 0);
      begin
        repeat (6) @(negedge clk);
        check("bp_accepted", acc_cnt, 2);
        check("bp_in_ready", IN_READY, 0);
        stall = 0;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // reset mid-operation
    model_op({TW{1'b1}}, TW'(5), 1'b1);
    send_word({N{1'b1}}, N'(5), 1'b1);
    send_word({N{1'b1}}, '0, 1'b0);
    RST = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    RST = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", OUT_VALID, 0);
    check("midrst_in_ready", IN_READY, 1);
    @(posedge clk); #1;
    send_op('0, '0, 1'b1, 0);

    // randomized traffic with random backpressure and gaps
    rnd = 1;
    for (int k = 0; k < 40; k++)
      send_op(rnd_op(), rnd_op(), 1'($urandom), 1);
    rnd = 0;

    t = 0;
    while (q.size() != 0 && t < 1000) begin
      t++;
      @(posedge clk);
    end
    check("drain", q.size(), 0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
